// File: rtl/dpmem_port_sequencer.sv
// Command FIFO + issue FSM for one DP_MEM port, one outstanding read.
// Define DPMEM_SEQ_STATS_EN to add the wr_count/rd_count outputs.
module dpmem_port_sequencer #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              busy
`ifdef DPMEM_SEQ_STATS_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RSP
  } state_t;

  state_t state, state_nxt;

  logic              f_op    [FIFO_DEPTH];
  logic [ADDR_W-1:0] f_addr  [FIFO_DEPTH];
  logic [DATA_W-1:0] f_wdata [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]    lat_cnt;

  logic              push, pop;
  logic              head_op;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign head_op    = f_op[rd_ptr];
  assign head_addr  = f_addr[rd_ptr];
  assign head_wdata = f_wdata[rd_ptr];

  // Full check uses registered count only; no pass-through when full.
  assign cmd_ready = (count < CW'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ISSUE) && mem_ready;
  assign count_nxt = count + CW'(push) - CW'(pop);

  assign mem_valid = (state == ISSUE);
  assign mem_op    = mem_valid && head_op;
  assign mem_addr  = mem_valid ? head_addr : '0;
  assign mem_wdata = mem_valid ? head_wdata : '0;
  assign rsp_valid = (state == RSP);
  assign busy      = (count != '0) || (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (count != '0) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (mem_ready) begin
          if (head_op) state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
          else         state_nxt = WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (lat_cnt == 2'd1) state_nxt = RSP;
      end
      RSP: begin
        if (rsp_ready) state_nxt = (count_nxt != '0) ? ISSUE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_op[wr_ptr]    <= cmd_op;
      f_addr[wr_ptr]  <= cmd_addr;
      f_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      lat_cnt   <= '0;
      rsp_addr  <= '0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (pop && !head_op) begin
        rsp_addr <= head_addr;
        lat_cnt  <= 2'(RD_LAT);
      end else if (state == WAIT_RD) begin
        lat_cnt <= lat_cnt - 2'd1;
        // last count step lands exactly RD_LAT edges after acceptance
        if (lat_cnt == 2'd1) rsp_rdata <= mem_rdata;
      end
    end
  end

`ifdef DPMEM_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (pop && head_op && wr_count != 16'hFFFF)
        wr_count <= wr_count + 16'd1;
      if (rsp_valid && rsp_ready && rd_count != 16'hFFFF)
        rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
